// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per CALC cycle, sign fix-up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic               start_fire;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               b_zero;

  assign start_fire = (state_q == S_IDLE) && start;
  assign a_neg      = op[0] & a[WIDTH-1];
  assign b_neg      = op[0] & b[WIDTH-1];
  assign a_mag      = neg_w(a, a_neg);
  assign b_mag      = neg_w(b, b_neg);

  // Multiply step: conditionally add multiplier into upper half, then shift right.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_mag_q};
  assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide step: the borrow out of the WIDTH+1-bit trial subtraction decides the quotient bit.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag_q};
  assign fits    = ~diff[WIDTH];

  assign prod_fix = neg_2w(acc_q, sign_a_q ^ sign_b_q);
  assign quo_fix  = neg_w(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
  assign rem_fix  = neg_w(rem_q, sign_a_q);
  assign b_zero   = (b_mag_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = CNT_W'(WIDTH - 1);
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = is_div_q && b_zero;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    if (start_fire) begin
      is_div_d = op[1];
      sign_a_d = a_neg;
      sign_b_d = b_neg;
      a_raw_d  = a;
      b_mag_d  = b_mag;
      acc_d    = {{WIDTH{1'b0}}, a_mag};
      rem_d    = '0;
    end else if (state_q == S_CALC) begin
      if (is_div_q) begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], fits};
        rem_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      end else begin
        acc_d = mul_next;
      end
    end
  end

  // Control and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers: only meaningful between capture and FIX.
  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    sign_a_q <= sign_a_d;
    sign_b_q <= sign_b_d;
    a_raw_q  <= a_raw_d;
    b_mag_q  <= b_mag_d;
    acc_q    <= acc_d;
    rem_q    <= rem_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle, plus directed literal results.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: results straight from the MIPS-style definitions.
  function automatic void reference(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rd = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == '0) begin
          rd = 1'b1; rh = x; rl = '1;
        end else if (o == 2'b10) begin
          rl = x / y; rh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = x; rh = '0;
        end else begin
          rl = 32'(sx / sy); rh = 32'(sx % sy);
        end
      end
    endcase
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           m_left = 0;
  logic [W-1:0] p_hi, p_lo;
  logic         p_dbz;

  // Model: result computed at launch, published W+1 edges later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz;
          m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (start) begin
        reference(op, a, b, p_hi, p_lo, p_dbz);
        m_left <= W + 1;
        m_busy <= 1'b1;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_busy));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_dbz", 64'(div_by_zero), 64'(m_dbz));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  // mode 0: plain; 1: disturb inputs mid-operation; 2: hi_we alongside start.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int mode);
    int n;
    int bcnt;
    bit seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (mode == 2) begin hi_we = 1'b1; wdata = 32'hAAAA_AAAA; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; a = ~x; b = ~y;
    n = 1; bcnt = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      else begin
        if (mode == 1 && n == 5) begin
          start = 1'b1; lo_we = 1'b1; hi_we = 1'b1; wdata = '1; op = ~o; a = 32'h1234_5678; b = 32'h9;
        end
        if (mode == 1 && n == 6) begin start = 1'b0; lo_we = 1'b0; hi_we = 1'b0; end
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end else begin
      check({name, "_hi"}, 64'(hi), 64'(eh));
      check({name, "_lo"}, 64'(lo), 64'(el));
      check({name, "_dbz"}, 64'(div_by_zero), 64'(ed));
      check({name, "_done_lat"}, 64'(n), 64'd34);
      check({name, "_busy_cyc"}, 64'(bcnt), 64'd33);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    run_op("div_zero", 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("multu_2_3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi_lo", 64'(lo), 64'd6);
    check("mthi_done", 64'(done), 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", 64'(hi), 64'hCAFE_F00D);
    check("mtboth_lo", 64'(lo), 64'hCAFE_F00D);

    run_op("multu_busy_ign", 2'b00, 32'h0001_0001, 32'h0001_0000, 32'h0000_0001, 32'h0001_0000, 1'b0, 1);
    run_op("start_wins", 2'b10, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 2);

    @(negedge clk);
    op = 2'b01; a = 32'h0000_1234; b = 32'hFFFF_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op("divu_9_4", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
